// File: rtl/bounce_monitor.sv
// Observer for a bouncing up/down counter: tracks direction, counts turning points
// and latches the first illegal step. Optional min/max tracking: BOUNCE_MON_MINMAX_EN.
module bounce_monitor #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             d_valid,
    input  logic [W-1:0]     d_in,
    output logic             dir_up,
    output logic             top_turn,
    output logic             bot_turn,
    output logic [CNT_W-1:0] peak_cnt,
    output logic [CNT_W-1:0] vall_cnt,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [W-1:0]     min_seen,
    output logic [W-1:0]     max_seen
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_UP,
        ST_DOWN,
        ST_ERROR
    } state_e;

    localparam logic [1:0]       EC_NONE  = 2'b00;
    localparam logic [1:0]       EC_STALL = 2'b01;
    localparam logic [1:0]       EC_JUMP  = 2'b10;
    localparam logic [1:0]       EC_WRAP  = 2'b11;
    localparam logic [W-1:0]     VAL_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [W-1:0]       prev_q, prev_d;
    logic               dir_q, dir_d;
    logic               top_q, top_d;
    logic               bot_q, bot_d;
    logic [CNT_W-1:0]   peak_q, peak_d;
    logic [CNT_W-1:0]   vall_q, vall_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;

    logic [W-1:0]       step_c;
    logic               wrap_c;
    logic               inc_c;
    logic               dec_c;
    logic [1:0]         bad_code_c;
    logic               bad_c;
    logic               take_c;

    // Step classification; a boundary wrap is illegal even though it is +/-1 mod 2^W
    always_comb begin
        step_c     = W'(d_in - prev_q);
        wrap_c     = ((prev_q == VAL_MAX) && (d_in == '0)) ||
                     ((prev_q == '0) && (d_in == VAL_MAX));
        inc_c      = (step_c == W'(1)) && !wrap_c;
        dec_c      = (step_c == VAL_MAX) && !wrap_c;
        bad_code_c = EC_NONE;
        if (wrap_c) begin
            bad_code_c = EC_WRAP;
        end else if (step_c == '0) begin
            bad_code_c = EC_STALL;
        end else if (!inc_c && !dec_c) begin
            bad_code_c = EC_JUMP;
        end
        bad_c  = (bad_code_c != EC_NONE);
        take_c = d_valid && (state_q != ST_ERROR);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        top_d   = 1'b0;
        bot_d   = 1'b0;
        peak_d  = peak_q;
        vall_d  = vall_q;
        err_d   = err_q;
        code_d  = code_q;

        if (clr) begin
            state_d = ST_IDLE;
            prev_d  = '0;
            peak_d  = '0;
            vall_d  = '0;
            err_d   = 1'b0;
            code_d  = EC_NONE;
        end else if (take_c) begin
            prev_d = d_in;
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (bad_c)      state_d = ST_ERROR;
                    else if (inc_c) state_d = ST_UP;
                    else            state_d = ST_DOWN;
                end
                ST_UP: begin
                    if (bad_c) begin
                        state_d = ST_ERROR;
                    end else if (dec_c) begin
                        state_d = ST_DOWN;
                        top_d   = 1'b1;
                        peak_d  = (peak_q == CNT_MAX) ? peak_q : peak_q + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (bad_c) begin
                        state_d = ST_ERROR;
                    end else if (inc_c) begin
                        state_d = ST_UP;
                        bot_d   = 1'b1;
                        vall_d  = (vall_q == CNT_MAX) ? vall_q : vall_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Only the first error is recorded; ERROR holds until rst/clr
            if ((state_d == ST_ERROR) && !err_q) begin
                err_d  = 1'b1;
                code_d = bad_code_c;
            end
        end

        dir_d = (state_d == ST_UP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            dir_q   <= 1'b0;
            top_q   <= 1'b0;
            bot_q   <= 1'b0;
            peak_q  <= '0;
            vall_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= EC_NONE;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            dir_q   <= dir_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            peak_q  <= peak_d;
            vall_q  <= vall_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign dir_up   = dir_q;
    assign top_turn = top_q;
    assign bot_turn = bot_q;
    assign peak_cnt = peak_q;
    assign vall_cnt = vall_q;
    assign err      = err_q;
    assign err_code = code_q;

`ifdef BOUNCE_MON_MINMAX_EN
    logic [W-1:0] min_q, min_d;
    logic [W-1:0] max_q, max_d;

    // Extremes include the IDLE sample and the sample that triggers an error
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clr) begin
            min_d = VAL_MAX;
            max_d = '0;
        end else if (take_c) begin
            if (d_in < min_q) min_d = d_in;
            if (d_in > max_q) max_d = d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= VAL_MAX;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_seen = min_q;
    assign max_seen = max_q;
`else
    assign min_seen = '0;
    assign max_seen = '0;
`endif

endmodule

// File: tb/tb_bounce_monitor.sv
// Scoreboard bench for bounce_monitor: driver queues hand-computed expectations,
// a monitor pops and compares one entry per clock after the DUT registers update.
module tb_bounce_monitor;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       d_valid;
    logic [3:0] d_in;
    logic       dir_up;
    logic       top_turn;
    logic       bot_turn;
    logic [7:0] peak_cnt;
    logic [7:0] vall_cnt;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] min_seen;
    logic [3:0] max_seen;

    bounce_monitor #(.W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .d_valid  (d_valid),
        .d_in     (d_in),
        .dir_up   (dir_up),
        .top_turn (top_turn),
        .bot_turn (bot_turn),
        .peak_cnt (peak_cnt),
        .vall_cnt (vall_cnt),
        .err      (err),
        .err_code (err_code),
        .min_seen (min_seen),
        .max_seen (max_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        string       nm;
        logic [29:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic       e_dir, e_top, e_bot, e_er;
    logic [7:0] e_pk, e_vl;
    logic [1:0] e_cd;
    logic [3:0] e_mn, e_mx;

    function automatic logic [3:0] mm(input logic [3:0] x);
`ifdef BOUNCE_MON_MINMAX_EN
        return x;
`else
        return x & 4'h0;
`endif
    endfunction

    function automatic logic [7:0] sat8(input int k);
        return (k > 255) ? 8'hFF : 8'(k);
    endfunction

    task automatic set_reset_exp();
        e_dir = 1'b0; e_top = 1'b0; e_bot = 1'b0; e_er = 1'b0;
        e_pk  = 8'h00; e_vl = 8'h00; e_cd = 2'b00;
        e_mn  = 4'hF;  e_mx = 4'h0;
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic [3:0] d,
                         input bit chk, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; clr = c; d_valid = v; d_in = d;
        e.chk = chk;
        e.nm  = nm;
        e.v   = {e_dir, e_top, e_bot, e_pk, e_vl, e_er, e_cd, mm(e_mn), mm(e_mx)};
        exp_q.push_back(e);
    endtask

    task automatic smp(input logic [3:0] d, input bit chk, input string nm);
        drive(1'b0, 1'b0, 1'b1, d, chk, nm);
    endtask

    task automatic reset_dut();
        set_reset_exp();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "reset");
    endtask

    // Monitor: registered outputs are stable 1 time unit after the active edge
    initial begin
        exp_t        e;
        logic [29:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    got = {dir_up, top_turn, bot_turn, peak_cnt, vall_cnt, err, err_code,
                           min_seen, max_seen};
                    n_chk++;
                    if (got === e.v) n_pass++;
                    else $display("FAIL %s: got %h expected %h (dir,top,bot,pk,vl,err,code,min,max)",
                                  e.nm, got, e.v);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; d_valid = 1'b0; d_in = 4'h0;
        set_reset_exp();

        // 1: full up-then-down run with one peak and one valley
        reset_dut();
        e_mn = 4'd0; e_mx = 4'd0;
        smp(4'd0, 1'b1, "idle_smp");
        e_dir = 1'b1; e_mx = 4'd1;
        smp(4'd1, 1'b1, "arm_up");
        for (int i = 2; i <= 14; i++) begin
            e_mx = 4'(i);
            smp(4'(i), 1'b1, "count_up");
        end
        e_dir = 1'b0; e_top = 1'b1; e_pk = 8'd1;
        smp(4'd13, 1'b1, "top_turn");
        e_top = 1'b0;
        for (int i = 12; i >= 1; i--) smp(4'(i), 1'b1, "count_down");
        e_dir = 1'b1; e_bot = 1'b1; e_vl = 8'd1;
        smp(4'd2, 1'b1, "bot_turn");
        e_bot = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd7, 1'b1, "idle_hold");

        // 2: stall error, later samples ignored
        reset_dut();
        e_mn = 4'd5; e_mx = 4'd5;
        smp(4'd5, 1'b1, "t2_idle");
        e_dir = 1'b1; e_mx = 4'd6;
        smp(4'd6, 1'b1, "t2_up");
        e_dir = 1'b0; e_er = 1'b1; e_cd = 2'b01;
        smp(4'd6, 1'b1, "stall");
        smp(4'd7, 1'b1, "err_frozen7");
        smp(4'd8, 1'b1, "err_frozen8");

        // 3: wrap error, then jump error after reset
        reset_dut();
        e_mn = 4'd14; e_mx = 4'd14;
        smp(4'd14, 1'b0, "");
        e_dir = 1'b1; e_mx = 4'd15;
        smp(4'd15, 1'b1, "t3_up");
        e_dir = 1'b0; e_er = 1'b1; e_cd = 2'b11; e_mn = 4'd0;
        smp(4'd0, 1'b1, "wrap");
        reset_dut();
        e_mn = 4'd3; e_mx = 4'd3;
        smp(4'd3, 1'b0, "");
        e_er = 1'b1; e_cd = 2'b10; e_mx = 4'd7;
        smp(4'd7, 1'b1, "jump");

        // 4: 256 bounce periods between 5 and 7 saturate both counters
        reset_dut();
        e_mn = 4'd5; e_mx = 4'd7;
        smp(4'd5, 1'b0, "");
        for (int k = 1; k <= 256; k++) begin
            smp(4'd6, 1'b0, "");
            smp(4'd7, 1'b0, "");
            smp(4'd6, 1'b0, "");
            e_dir = 1'b0; e_top = 1'b0; e_bot = 1'b0;
            e_pk = sat8(k); e_vl = sat8(k - 1);
            smp(4'd5, 1'b1, "bounce_period");
        end
        e_dir = 1'b1; e_bot = 1'b1; e_vl = 8'hFF;
        smp(4'd6, 1'b1, "vall_sat");

        // 5: clr with a valid sample mid-UP drops the sample
        reset_dut();
        smp(4'd4, 1'b0, "");
        smp(4'd5, 1'b0, "");
        e_dir = 1'b1; e_mn = 4'd4; e_mx = 4'd6;
        smp(4'd6, 1'b1, "t5_up");
        set_reset_exp();
        drive(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, "clr");
        e_mn = 4'd10; e_mx = 4'd10;
        smp(4'd10, 1'b1, "post_clr_idle");
        e_dir = 1'b1; e_mx = 4'd11;
        smp(4'd11, 1'b1, "post_clr_up");

        // 6: min/max tracking then reset back to F/0
        reset_dut();
        e_mn = 4'd3; e_mx = 4'd3;
        smp(4'd3, 1'b0, "");
        e_dir = 1'b1; e_mx = 4'd4;
        smp(4'd4, 1'b0, "");
        e_mx = 4'd5;
        smp(4'd5, 1'b0, "");
        e_dir = 1'b0; e_top = 1'b1; e_pk = 8'd1;
        smp(4'd4, 1'b1, "mm_top");
        e_top = 1'b0;
        smp(4'd3, 1'b0, "");
        e_mn = 4'd2;
        smp(4'd2, 1'b1, "minmax");
        reset_dut();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
